// File: rtl/text_buffer_ctrl.sv
// Keyboard-to-character-RAM controller: queues keystrokes, moves the cursor, writes the RAM
// and sweeps it clear. VGA character fetches always take the single RAM port first.
module text_buffer_ctrl #(
  parameter int COLS       = 40,
  parameter int ROWS       = 30,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_VGA,
  input  logic        reset,
  input  logic        key_valid,
  input  logic [7:0]  key_ascii,
  output logic        key_ready,
  input  logic        fetch_req,
  input  logic [10:0] fetch_addr,
  output logic        fetch_valid,
  output logic [7:0]  fetch_data,
  output logic [10:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [5:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy,
  output logic        overflow
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [5:0]    LAST_COL  = 6'(COLS - 1);
  localparam logic [4:0]    LAST_ROW  = 5'(ROWS - 1);
  localparam logic [10:0]   COLS_W    = 11'(COLS);
  localparam logic [10:0]   LAST_ADDR = 11'(COLS * ROWS - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, CLEAR} state_t;

  state_t        r_state, w_next;
  logic          r_kv;
  logic [7:0]    r_ka;
  logic [7:0]    r_fifo [FIFO_DEPTH];
  logic [PW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [5:0]    r_col;
  logic [4:0]    r_row;
  logic [10:0]   r_addr;
  logic [7:0]    r_data;
  logic          r_adv;
  logic [10:0]   r_clr;
  logic          r_fv;

  logic          w_full, w_empty, w_push, w_pop, w_we;
  logic [7:0]    w_head;
  logic          w_printable;
  logic [10:0]   w_row_base;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push      = r_kv && !w_full;
  assign w_head      = r_fifo[r_rp];
  assign w_printable = (w_head >= 8'h20) && (w_head <= 8'h7E);
  assign w_row_base  = 11'(r_row) * COLS_W;

  // Decoding happens on the pop edge; only IDLE ever pops.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_printable)                           w_next = WRITE;
          else if (w_head == 8'h08 && r_col != 6'd0) w_next = WRITE;
          else if (w_head == 8'h0C)                  w_next = CLEAR;
        end
      end
      WRITE: begin
        if (!fetch_req) begin
          w_we   = 1'b1;
          w_next = IDLE;
        end
      end
      CLEAR: begin
        if (!fetch_req) begin
          w_we = 1'b1;
          if (r_clr == LAST_ADDR) w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_VGA or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Keystrokes pass through one input register before the FIFO.
  always_ff @(posedge clk_VGA or negedge reset) begin
    if (!reset) begin
      r_kv       <= 1'b0;
      r_ka       <= 8'h00;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_fifo[i] <= 8'h00;
    end else begin
      r_kv <= key_valid;
      r_ka <= key_ascii;
      if (w_push) begin
        r_fifo[r_wp] <= r_ka;
        r_wp         <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (r_kv && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_VGA or negedge reset) begin
    if (!reset) begin
      r_col  <= 6'd0;
      r_row  <= 5'd0;
      r_addr <= 11'd0;
      r_data <= 8'h00;
      r_adv  <= 1'b0;
      r_clr  <= 11'd0;
      r_fv   <= 1'b0;
    end else begin
      r_fv <= fetch_req;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            if (w_printable) begin
              r_addr <= w_row_base + 11'(r_col);
              r_data <= w_head;
              r_adv  <= 1'b1;
            end else if (w_head == 8'h0D) begin
              r_col <= 6'd0;
              r_row <= (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
            end else if (w_head == 8'h08 && r_col != 6'd0) begin
              r_col  <= r_col - 6'd1;
              r_addr <= w_row_base + 11'(r_col - 6'd1);
              r_data <= 8'h20;
              r_adv  <= 1'b0;
            end else if (w_head == 8'h0C) begin
              r_clr <= 11'd0;
            end
          end
        end
        WRITE: begin
          if (!fetch_req && r_adv) begin
            if (r_col == LAST_COL) begin
              r_col <= 6'd0;
              r_row <= (r_row == LAST_ROW) ? 5'd0 : r_row + 5'd1;
            end else begin
              r_col <= r_col + 6'd1;
            end
          end
        end
        CLEAR: begin
          if (!fetch_req) begin
            r_clr <= r_clr + 11'd1;
            if (r_clr == LAST_ADDR) begin
              r_col <= 6'd0;
              r_row <= 5'd0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign key_ready   = !w_full;
  assign overflow    = r_overflow;
  assign busy        = (r_state == CLEAR);
  assign cursor_col  = r_col;
  assign cursor_row  = r_row;
  assign mem_we      = w_we;
  assign mem_addr    = fetch_req ? fetch_addr : ((r_state == CLEAR) ? r_clr : r_addr);
  assign mem_wdata   = (r_state == CLEAR) ? 8'h20 : r_data;
  assign fetch_valid = r_fv;
  assign fetch_data  = r_fv ? mem_rdata : 8'h00;

endmodule
